// File: rtl/ball_motion_controller_if.sv
// Frame/collision/paddle inputs and sprite position/status outputs of the ball motion controller.
interface ball_motion_controller_if;
  logic               startOfFrame;
  logic               collision;
  logic [3:0]         hitEdgeCode;
  logic signed [10:0] paddleX;
  logic               launch;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic [2:0]         lives;
  logic [1:0]         state;

  modport master (
    output startOfFrame, collision, hitEdgeCode, paddleX, launch,
    input  topLeftX, topLeftY, lives, state
  );

  modport slave (
    input  startOfFrame, collision, hitEdgeCode, paddleX, launch,
    output topLeftX, topLeftY, lives, state
  );
endinterface

// File: rtl/ball_motion_controller.sv
// Ball sprite motion: fixed-point position, per-frame bounce/move, serve/play/lost/over sequencing.
module ball_motion_controller #(
  parameter int FIXED_SHIFT       = 6,
  parameter int INITIAL_Y         = 400,
  parameter int PADDLE_CENTER_OFS = 24,
  parameter int INIT_SPEED_X      = 64,
  parameter int INIT_SPEED_Y      = -128,
  parameter int LOST_Y            = 470,
  parameter int LOST_FRAMES       = 60,
  parameter int LIVES             = 3
) (
  input logic clk,
  input logic resetN,
  ball_motion_controller_if.slave bus
);
  localparam int PW = 11 + FIXED_SHIFT;
  localparam logic signed [10:0] LOST_Y_PX   = 11'(LOST_Y);
  localparam logic signed [10:0] SERVE_Y_PX  = 11'(INITIAL_Y);
  localparam logic signed [10:0] OFS_PX      = 11'(PADDLE_CENTER_OFS);
  localparam logic signed [10:0] LAUNCH_VX   = 11'(INIT_SPEED_X);
  localparam logic signed [10:0] LAUNCH_VY   = 11'(INIT_SPEED_Y);
  localparam logic [15:0]        LOST_LAST   = 16'(LOST_FRAMES - 1);
  localparam logic [2:0]         LIVES_INIT  = 3'(LIVES);
  localparam logic [FIXED_SHIFT-1:0] FRAC0   = '0;

  typedef enum logic [1:0] {
    S_SERVE = 2'b00,
    S_PLAY  = 2'b01,
    S_LOST  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t               st;
  logic signed [PW-1:0] pos_x, pos_y;
  logic signed [10:0]   speed_x, speed_y;
  logic [3:0]           hit_latch;
  logic [2:0]           lives_q;
  logic [15:0]          lost_cnt;

  logic signed [10:0]   bounce_x, bounce_y, serve_tl_x, next_top_y;
  logic signed [PW-1:0] next_x, next_y;

  always_comb begin
    bounce_x = speed_x;
    bounce_y = speed_y;
    // A hit only reverses motion that is heading into the touched edge.
    if ((hit_latch[0] && speed_x[10]) || (hit_latch[2] && !speed_x[10] && speed_x != '0))
      bounce_x = -speed_x;
    if ((hit_latch[1] && speed_y[10]) || (hit_latch[3] && !speed_y[10] && speed_y != '0))
      bounce_y = -speed_y;
    next_x     = pos_x + {{FIXED_SHIFT{bounce_x[10]}}, bounce_x};
    next_y     = pos_y + {{FIXED_SHIFT{bounce_y[10]}}, bounce_y};
    next_top_y = next_y[PW-1:FIXED_SHIFT];
    serve_tl_x = bus.paddleX + OFS_PX;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      st        <= S_SERVE;
      lives_q   <= LIVES_INIT;
      speed_x   <= '0;
      speed_y   <= '0;
      hit_latch <= '0;
      lost_cnt  <= '0;
      pos_x     <= {OFS_PX, FRAC0};
      pos_y     <= {SERVE_Y_PX, FRAC0};
    end else begin
      // A hit coincident with the frame pulse belongs to the next frame.
      if (bus.startOfFrame)
        hit_latch <= bus.collision ? bus.hitEdgeCode : '0;
      else if (bus.collision)
        hit_latch <= hit_latch | bus.hitEdgeCode;

      if (bus.startOfFrame) begin
        unique case (st)
          S_SERVE: begin
            pos_x <= {serve_tl_x, FRAC0};
            pos_y <= {SERVE_Y_PX, FRAC0};
            if (bus.launch) begin
              speed_x <= LAUNCH_VX;
              speed_y <= LAUNCH_VY;
              st      <= S_PLAY;
            end
          end
          S_PLAY: begin
            speed_x <= bounce_x;
            speed_y <= bounce_y;
            pos_x   <= next_x;
            pos_y   <= next_y;
            if (next_top_y >= LOST_Y_PX) begin
              lost_cnt <= '0;
              lives_q  <= lives_q - 3'd1;
              st       <= (lives_q == 3'd1) ? S_OVER : S_LOST;
            end
          end
          S_LOST: begin
            if (lost_cnt == LOST_LAST)
              st <= S_SERVE;
            else
              lost_cnt <= lost_cnt + 16'd1;
          end
          S_OVER: lives_q <= '0;
        endcase
      end
    end
  end

  assign bus.topLeftX = pos_x[PW-1:FIXED_SHIFT];
  assign bus.topLeftY = pos_y[PW-1:FIXED_SHIFT];
  assign bus.lives    = lives_q;
  assign bus.state    = st;
endmodule

// File: tb/tb_ball_motion_controller.sv
// Self-checking bench: directed scenarios plus randomized frames against a behavioural ball model.
module tb_ball_motion_controller;
  logic clk = 1'b0;
  logic resetN;
  int   tests = 0;
  int   failed = 0;

  ball_motion_controller_if bus();

  ball_motion_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: pixel positions in 1/64 units, mode 0 serve / 1 play / 2 lost / 3 over.
  int         m_mode, m_x, m_y, m_vx, m_vy, m_lives, m_lostn;
  logic [3:0] m_hits;

  function automatic int wrap(input int v, input int bits);
    int t;
    t = v << (32 - bits);
    return t >>> (32 - bits);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_x = 24 * 64; m_y = 400 * 64;
    m_vx = 0; m_vy = 0; m_lives = 3; m_lostn = 0; m_hits = 4'b0;
  endtask

  task automatic model_step();
    logic [3:0] used;
    if (bus.startOfFrame) begin
      used   = m_hits;
      m_hits = bus.collision ? bus.hitEdgeCode : 4'b0;
      case (m_mode)
        0: begin
          m_x = wrap(bus.paddleX + 24, 11) * 64;
          m_y = 400 * 64;
          if (bus.launch) begin m_vx = 64; m_vy = -128; m_mode = 1; end
        end
        1: begin
          if ((used[0] && m_vx < 0) || (used[2] && m_vx > 0)) m_vx = -m_vx;
          if ((used[1] && m_vy < 0) || (used[3] && m_vy > 0)) m_vy = -m_vy;
          m_x = wrap(m_x + m_vx, 17);
          m_y = wrap(m_y + m_vy, 17);
          if ((m_y >>> 6) >= 470) begin
            m_lives = m_lives - 1;
            m_lostn = 0;
            m_mode  = (m_lives == 0) ? 3 : 2;
          end
        end
        2: begin
          m_lostn = m_lostn + 1;
          if (m_lostn == 60) m_mode = 0;
        end
        default: ;
      endcase
    end else if (bus.collision) begin
      m_hits = m_hits | bus.hitEdgeCode;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (resetN) model_step();
  end

  initial forever begin
    @(negedge clk);
    if (resetN) begin
      chk("model_x", bus.topLeftX, m_x >>> 6);
      chk("model_y", bus.topLeftY, m_y >>> 6);
      chk("model_lives", bus.lives, m_lives);
      chk("model_state", bus.state, m_mode);
    end
  end

  task automatic step(input logic sof, input logic col, input logic [3:0] code);
    bus.startOfFrame = sof; bus.collision = col; bus.hitEdgeCode = code;
    @(posedge clk); #2;
    bus.startOfFrame = 1'b0; bus.collision = 1'b0; bus.hitEdgeCode = 4'b0;
  endtask

  task automatic frame(input int idle);
    step(1'b1, 1'b0, 4'b0);
    repeat (idle) step(1'b0, 1'b0, 4'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"}, bus.topLeftX, 24);
    chk({tag, "_y"}, bus.topLeftY, 400);
    chk({tag, "_lives"}, bus.lives, 3);
    chk({tag, "_state"}, bus.state, 0);
  endtask

  task automatic async_reset();
    resetN = 1'b0;
    model_reset();
    #1;
    check_reset_values("async_rst");
    @(posedge clk); #2;
    resetN = 1'b1;
  endtask

  task automatic wait_lost(output int n);
    n = 0;
    while (bus.state == 2'b01 && n < 200) begin frame(1); n++; end
    chk("lost_timeout", int'(n < 200), 1);
  endtask

  task automatic lose_life(input int exp_lives, input int exp_state);
    int n;
    bus.launch = 1'b1; frame(2); bus.launch = 1'b0;
    frame(2);
    step(1'b0, 1'b1, 4'b0010);
    wait_lost(n);
    chk("lost_lives", bus.lives, exp_lives);
    chk("lost_state", bus.state, exp_state);
    if (exp_state == 2) begin
      repeat (59) frame(1);
      chk("lost_hold59", bus.state, 2);
      frame(1);
      chk("reserve60", bus.state, 0);
    end
  endtask

  initial begin
    int n;
    resetN = 1'b0;
    bus.startOfFrame = 1'b0; bus.collision = 1'b0; bus.hitEdgeCode = 4'b0;
    bus.paddleX = 11'sd100; bus.launch = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
    check_reset_values("reset");

    frame(3);
    chk("serve_x", bus.topLeftX, 124);
    bus.launch = 1'b1; step(1'b1, 1'b0, 4'b0); bus.launch = 1'b0;
    chk("launch_state", bus.state, 1);
    chk("launch_x", bus.topLeftX, 124);
    step(1'b0, 1'b0, 4'b0); step(1'b0, 1'b0, 4'b0);
    frame(2);
    chk("f2_x", bus.topLeftX, 125); chk("f2_y", bus.topLeftY, 398);
    frame(2);
    chk("f3_x", bus.topLeftX, 126); chk("f3_y", bus.topLeftY, 396);
    step(1'b0, 1'b1, 4'b0010); frame(2);
    chk("top_bounce_y", bus.topLeftY, 398);
    step(1'b0, 1'b1, 4'b0010); frame(2);
    chk("top_no_rebounce_y", bus.topLeftY, 400);
    chk("pre_lr_x", bus.topLeftX, 128);
    step(1'b0, 1'b1, 4'b0101); frame(2);
    chk("lr_bounce_x", bus.topLeftX, 127);
    step(1'b1, 1'b1, 4'b0001); step(1'b0, 1'b0, 4'b0);
    chk("coincident_deferred_x", bus.topLeftX, 126);
    frame(2);
    chk("coincident_applied_x", bus.topLeftX, 127);
    chk("descent_y", bus.topLeftY, 406);
    wait_lost(n);
    chk("first_lost_state", bus.state, 2);
    chk("first_lost_lives", bus.lives, 2);
    chk("first_lost_y", bus.topLeftY, 470);
    repeat (5) frame(1);
    step(1'b0, 1'b1, 4'b1111);
    async_reset();

    lose_life(2, 2);
    lose_life(1, 2);
    lose_life(0, 3);
    bus.launch = 1'b1; repeat (5) frame(1); bus.launch = 1'b0;
    chk("over_state", bus.state, 3);
    chk("over_lives", bus.lives, 0);

    async_reset();
    for (int f = 0; f < 1500; f++) begin
      bus.paddleX = 11'($urandom_range(0, 2047));
      bus.launch  = ($urandom_range(0, 3) != 0);
      step(1'b1, ($urandom_range(0, 3) == 0), 4'($urandom));
      if ($urandom_range(0, 149) == 0) async_reset();
      for (int c = 0; c < int'($urandom_range(1, 7)); c++)
        step(1'b0, ($urandom_range(0, 2) == 0), 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
